// File: rtl/commit_unit_pkg.sv
// commit_unit_pkg: shared sizes, index widths and FSM state type for the commit stage.
package commit_unit_pkg;
  localparam int AL_SIZE = 64;
  localparam int WINDOW = 4;
  localparam int AL_W = $clog2(AL_SIZE);
  localparam int WIN_W = $clog2(WINDOW);
  typedef enum logic [1:0] {IDLE, ST_REQ, ST_DONE} commit_state_e;
endpackage

// File: rtl/commit_window_scan.sv
// commit_window_scan: finds the contiguous ready run, the first eligible store and run-masked type flags.
module commit_window_scan
  import commit_unit_pkg::*;
#(
  parameter int W = WINDOW,
  localparam int WW = $clog2(W)
) (
  input  logic [W-1:0]  occ_i,
  input  logic [W-1:0]  rdy_i,
  input  logic [W-1:0]  ld_i,
  input  logic [W-1:0]  st_i,
  input  logic [W-1:0]  br_i,
  output logic [WW:0]   run_len_o,
  output logic          st_found_o,
  output logic [WW-1:0] st_pos_o,
  output logic [W-1:0]  ld_o,
  output logic [W-1:0]  st_o,
  output logic [W-1:0]  br_o
);
  logic [W-1:0] elig;
  logic         run;
  always_comb begin
    elig = '0;
    run = 1'b1;
    run_len_o = '0;
    st_found_o = 1'b0;
    st_pos_o = '0;
    for (int i = 0; i < W; i++) begin
      run = run & occ_i[i] & rdy_i[i];
      elig[i] = run;
      run_len_o = run_len_o + {{WW{1'b0}}, run};
      if (run && st_i[i] && !st_found_o) begin
        st_found_o = 1'b1;
        st_pos_o = WW'(i);
      end
    end
    ld_o = ld_i & elig;
    st_o = st_i & elig;
    br_o = br_i & elig;
  end
endmodule

// File: rtl/commit_unit.sv
// commit_unit: in-order retirement of the oldest ready run; stores retire singly via a d-cache handshake.
// Optional COMMIT_PERF_COUNTERS_EN adds saturating retired/store-stall counters.
module commit_unit #(
  parameter int AL_SIZE = commit_unit_pkg::AL_SIZE,
  parameter int WINDOW = commit_unit_pkg::WINDOW,
  localparam int AL_W = $clog2(AL_SIZE),
  localparam int WIN_W = $clog2(WINDOW)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_miss_i,
  input  logic [AL_SIZE-1:0] al_occupied_i,
  input  logic [AL_SIZE-1:0] al_ready_i,
  input  logic [AL_SIZE-1:0] al_is_load_i,
  input  logic [AL_SIZE-1:0] al_is_store_i,
  input  logic [AL_SIZE-1:0] al_is_branch_i,
  output logic               st_commit_req_o,
  input  logic               st_commit_ack_i,
  output logic               commit_valid_o,
  output logic [WIN_W-1:0]   last_valid_commit_idx_o,
  output logic [WINDOW-1:0]  load_valid_o,
  output logic [WINDOW-1:0]  store_valid_o,
  output logic [WINDOW-1:0]  branch_valid_o,
  output logic [AL_W-1:0]    oldest_ptr_o
`ifdef COMMIT_PERF_COUNTERS_EN
  ,
  output logic [31:0]        retired_count_o,
  output logic [31:0]        store_stall_cycles_o
`endif
);
  import commit_unit_pkg::*;
  commit_state_e     state_q;
  logic              st_req_q;
  logic [AL_W-1:0]   oldest_q, oldest_d;
  logic [WINDOW-1:0] w_occ, w_rdy, w_ld, w_st, w_br, s_ld, s_st, s_br, m;
  logic [WIN_W:0]    run_len, n_w;
  logic [WIN_W-1:0]  st_pos;
  logic              st_found, go_st;
  logic              unused_branch_miss;
  // The head is never flushed, so a flush needs no action here.
  assign unused_branch_miss = branch_miss_i;
  for (genvar i = 0; i < WINDOW; i++) begin : g_rot
    logic [AL_W-1:0] e;
    assign e = oldest_q + AL_W'(i);
    assign w_occ[i] = al_occupied_i[e];
    assign w_rdy[i] = al_ready_i[e];
    assign w_ld[i] = al_is_load_i[e];
    assign w_st[i] = al_is_store_i[e];
    assign w_br[i] = al_is_branch_i[e];
  end
  commit_window_scan #(.W(WINDOW)) u_scan (
    .occ_i(w_occ), .rdy_i(w_rdy), .ld_i(w_ld), .st_i(w_st), .br_i(w_br),
    .run_len_o(run_len), .st_found_o(st_found), .st_pos_o(st_pos),
    .ld_o(s_ld), .st_o(s_st), .br_o(s_br)
  );
  always_comb begin
    n_w = state_q == ST_REQ ? {{WIN_W{1'b0}}, st_commit_ack_i} :
          state_q == ST_DONE ? '0 :
          st_found ? {1'b0, st_pos} : run_len;
    for (int i = 0; i < WINDOW; i++) m[i] = (WIN_W + 1)'(i) < n_w;
    go_st = state_q == IDLE && st_found && st_pos == '0;
    oldest_d = oldest_q + AL_W'(n_w);
  end
  assign commit_valid_o = |n_w;
  assign last_valid_commit_idx_o = commit_valid_o ? WIN_W'(n_w - 1'b1) : '0;
  assign load_valid_o = s_ld & m;
  assign branch_valid_o = s_br & m;
  assign store_valid_o = state_q == ST_REQ ? WINDOW'(st_commit_ack_i) : s_st & m;
  assign st_commit_req_o = st_req_q;
  assign oldest_ptr_o = oldest_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_req_q <= 1'b0;
      oldest_q <= '0;
    end else begin
      oldest_q <= oldest_d;
      case (state_q)
        IDLE: if (go_st) begin
          state_q <= ST_REQ;
          st_req_q <= 1'b1;
        end
        ST_REQ: if (st_commit_ack_i) begin
          state_q <= ST_DONE;
          st_req_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef COMMIT_PERF_COUNTERS_EN
  logic [31:0] ret_q, stall_q;
  logic [32:0] ret_sum;
  assign ret_sum = {1'b0, ret_q} + 33'(n_w);
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_q <= '0;
      stall_q <= '0;
    end else begin
      ret_q <= ret_sum[32] ? '1 : ret_sum[31:0];
      if (state_q == ST_REQ && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end
  end
  assign retired_count_o = ret_q;
  assign store_stall_cycles_o = stall_q;
`endif
endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: directed + random stimulus, reference model feeds a scoreboard checked by a monitor.
module tb_commit_unit;
  logic        clk = 1'b0, rst, bm, ack;
  logic [63:0] occ, rdy, isl, iss, isb;
  logic        req, cv;
  logic [1:0]  idx;
  logic [3:0]  ldv, stv, brv;
  logic [5:0]  ptr;
`ifdef COMMIT_PERF_COUNTERS_EN
  logic [31:0] rc, sc;
`endif
  always #5 clk = ~clk;
  commit_unit dut (
    .clk(clk), .rst(rst), .branch_miss_i(bm),
    .al_occupied_i(occ), .al_ready_i(rdy),
    .al_is_load_i(isl), .al_is_store_i(iss), .al_is_branch_i(isb),
    .st_commit_req_o(req), .st_commit_ack_i(ack),
    .commit_valid_o(cv), .last_valid_commit_idx_o(idx),
    .load_valid_o(ldv), .store_valid_o(stv), .branch_valid_o(brv),
    .oldest_ptr_o(ptr)
`ifdef COMMIT_PERF_COUNTERS_EN
    , .retired_count_o(rc), .store_stall_cycles_o(sc)
`endif
  );
  typedef struct {
    bit       chk;
    bit       cv;
    bit [1:0] idx;
    bit [3:0] ld, st, br;
    bit       req;
    bit [5:0] ptr;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int mptr = 0, mode = 0;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        n_cmp++;
        if (cv !== e.cv || idx !== e.idx || ldv !== e.ld || stv !== e.st ||
            brv !== e.br || req !== e.req || ptr !== e.ptr) begin
          n_bad++;
          $display("FAIL bundle t=%0t got cv=%b idx=%0d ld=%b st=%b br=%b req=%b ptr=%0d want cv=%b idx=%0d ld=%b st=%b br=%b req=%b ptr=%0d",
                   $time, cv, idx, ldv, stv, brv, req, ptr, e.cv, e.idx, e.ld, e.st, e.br, e.req, e.ptr);
        end
      end
    end
  end
  initial begin
    #500000;
    n_bad++;
    $display("FAIL timeout: stimulus did not finish within the wait limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  task automatic clr();
    occ = '0; rdy = '0; isl = '0; iss = '0; isb = '0; bm = 1'b0; ack = 1'b0;
  endtask
  task automatic put(input int off, input int t);
    int s;
    s = (mptr + off) % 64;
    occ[s] = 1'b1; rdy[s] = 1'b1;
    isl[s] = t == 1; iss[s] = t == 2; isb[s] = t == 3;
  endtask
  task automatic step();
    exp_t e;
    int run, k, n;
    if (mode == 1) begin
      occ[mptr] = 1'b1; rdy[mptr] = 1'b1; iss[mptr] = 1'b1; isl[mptr] = 1'b0; isb[mptr] = 1'b0;
    end
    run = 0;
    while (run < 4 && occ[(mptr + run) % 64] && rdy[(mptr + run) % 64]) run++;
    k = -1;
    for (int i = 0; i < run; i++) if (k < 0 && iss[(mptr + i) % 64]) k = i;
    n = mode == 1 ? int'(ack) : mode == 2 ? 0 : (k >= 0 ? k : run);
    e.chk = !rst;
    e.cv = n > 0;
    e.idx = n > 0 ? 2'(n - 1) : 2'd0;
    e.ld = '0; e.st = '0; e.br = '0;
    for (int i = 0; i < n; i++) begin
      e.ld[i] = isl[(mptr + i) % 64];
      e.st[i] = iss[(mptr + i) % 64];
      e.br[i] = isb[(mptr + i) % 64];
    end
    e.req = mode == 1;
    e.ptr = 6'(mptr);
    q.push_back(e);
    if (rst) begin
      mptr = 0; mode = 0;
    end else begin
      mptr = (mptr + n) % 64;
      mode = mode == 0 ? (k == 0 ? 1 : 0) : mode == 1 ? (ack ? 2 : 1) : 0;
    end
    @(posedge clk); #1;
  endtask
  initial begin
    rst = 1'b1; clr();
    @(posedge clk); #1;
    n_cmp++;
    if (req !== 1'b0 || cv !== 1'b0 || ptr !== 6'd0 || idx !== 2'd0 ||
        ldv !== 4'd0 || stv !== 4'd0 || brv !== 4'd0) begin
      n_bad++;
      $display("FAIL reset t=%0t req=%b cv=%b ptr=%0d idx=%0d ld=%b st=%b br=%b",
               $time, req, cv, ptr, idx, ldv, stv, brv);
    end
    step(); step();
    rst = 1'b0;
    clr(); ack = 1'b1; step();
    clr(); for (int i = 0; i < 4; i++) put(i, 0); step();
    repeat (14) begin clr(); for (int i = 0; i < 4; i++) put(i, 0); step(); end
    clr(); put(0, 0); put(1, 0); step();
    clr(); for (int i = 0; i < 4; i++) put(i, i == 2 ? 3 : 0); step();
    clr(); put(0, 0); put(1, 2); put(2, 0); step();
    clr(); put(0, 2); put(1, 0); step();
    repeat (2) begin clr(); put(0, 2); step(); end
    clr(); put(0, 2); ack = 1'b1; step();
    clr(); step();
    clr(); put(0, 1); put(1, 0); put(2, 3); rdy[(mptr + 1) % 64] = 1'b0; step();
    clr(); put(0, 2); step();
    clr(); put(0, 2); step();
    rst = 1'b1; clr(); put(0, 2); step();
    rst = 1'b0; clr(); ack = 1'b1; step();
    clr(); put(0, 2); put(1, 1); put(2, 0); step();
    clr(); put(0, 2); bm = 1'b1; step();
    clr(); put(0, 2); ack = 1'b1; step();
    clr(); step();
    repeat (3000) begin
      for (int s = 0; s < 64; s++) begin
        int t;
        t = $urandom_range(7);
        occ[s] = $urandom_range(7) != 0;
        rdy[s] = $urandom_range(3) != 0;
        isl[s] = t == 1 || t == 2;
        iss[s] = t == 3;
        isb[s] = t == 4;
      end
      ack = $urandom_range(2) == 0;
      bm = $urandom_range(7) == 0;
      rst = $urandom_range(199) == 0;
      step();
    end
    rst = 1'b0; clr(); step();
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
